// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the hazard controller slice:
//   - md_state_t   : HI/LO unit occupancy state encoding (IDLE=0, BUSY=1)
//   - MULT_LAT_DEF : default multiply occupancy in cycles
//   - DIV_LAT_DEF  : default divide occupancy in cycles
//   - CNT_W        : width of the occupancy down-counter
//   - md_load()    : counter preload value for a newly issued mult/div
package hazard_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 32;
  localparam int CNT_W        = 5;

  // The counter counts down to zero inclusive, so a latency of N
  // cycles is loaded as N-1. A 32-cycle divide therefore fits in 5 bits.
  function automatic logic [CNT_W-1:0] md_load(input logic is_div,
                                               input int   mult_lat,
                                               input int   div_lat);
    int lat;
    lat = is_div ? div_lat : mult_lat;
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/md_busy_fsm.sv
// md_busy_fsm
// Tracks occupancy of the HI/LO multiply/divide unit.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : E-stage instruction is mult/multu/div/divu
//   is_div  : qualifies start, 1 = divide
//   md_busy : HI/LO unit occupied (high exactly while in BUSY)
module md_busy_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  md_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= BUSY;
            cnt_reg   <= md_load(is_div, MULT_LAT, DIV_LAT);
          end
        end
        BUSY: begin
          // A start seen here is deliberately ignored: the D-stage
          // md_stall keeps a second mult/div from reaching E while busy.
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign md_busy = (state_reg == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard unit: load-use, branch-operand and HI/LO-busy stalls,
// plus redirect flush. Stall/flush outputs are purely combinational.
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   rs_d, rt_d              : D-stage source register numbers
//   use_rs_d, use_rt_d      : D instruction actually reads rs / rt
//   branch_d                : D instruction resolves/reads registers in D
//   md_use_d                : D instruction touches the HI/LO unit
//   wr_reg_e, reg_write_e   : E-stage destination and its write enable
//   mem_to_reg_e            : E instruction is a load
//   md_start_e, md_is_div_e : E instruction starts mult/div (1 = divide)
//   wr_reg_m, mem_to_reg_m  : M-stage destination, M instruction is a load
//   flush_req               : redirect; kills D and E
//   pc_we, we_d             : PC and F/D register write enables
//   clear_d, clear_e        : synchronous clears of F/D and D/E registers
//   md_busy                 : HI/LO unit occupied
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       use_rs_d,
  input  logic       use_rt_d,
  input  logic       branch_d,
  input  logic       md_use_d,
  input  logic [4:0] wr_reg_e,
  input  logic       reg_write_e,
  input  logic       mem_to_reg_e,
  input  logic       md_start_e,
  input  logic       md_is_div_e,
  input  logic [4:0] wr_reg_m,
  input  logic       mem_to_reg_m,
  input  logic       flush_req,
  output logic       pc_we,
  output logic       we_d,
  output logic       clear_d,
  output logic       clear_e,
  output logic       md_busy
);

  // Source operand 0 = rs, 1 = rt.
  logic [1:0][4:0] src_reg;
  logic [1:0]      src_use;
  logic [1:0]      hit_e;
  logic [1:0]      hit_m;

  assign src_reg = {rt_d, rs_d};
  assign src_use = {use_rt_d, use_rs_d};

  // Register $0 is hardwired to zero, so it never creates a dependency.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
      assign hit_e[gi] = src_use[gi] && (wr_reg_e != 5'd0) && (src_reg[gi] == wr_reg_e);
      assign hit_m[gi] = src_use[gi] && (wr_reg_m != 5'd0) && (src_reg[gi] == wr_reg_m);
    end
  endgenerate

  logic match_e;
  logic match_m;
  logic lu_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  assign match_e  = |hit_e;
  assign match_m  = |hit_m;
  assign lu_stall = mem_to_reg_e && match_e;
  // Branches compare in D, so they also wait for ALU results still in E
  // and for load data still in M.
  assign br_stall = branch_d && ((reg_write_e && match_e) || (mem_to_reg_m && match_m));
  assign md_stall = md_use_d && (md_busy || md_start_e);
  assign stall    = lu_stall || br_stall || md_stall;

  // The branch delay slot executes, so only a redirect clears F/D.
  always_comb begin
    pc_we   = 1'b1;
    we_d    = 1'b1;
    clear_d = 1'b0;
    clear_e = 1'b0;
    if (flush_req) begin
      clear_d = 1'b1;
      clear_e = 1'b1;
    end else if (stall) begin
      pc_we   = 1'b0;
      we_d    = 1'b0;
      clear_e = 1'b1;
    end
  end

  // A redirect does not abort an in-flight multiply/divide.
  md_busy_fsm #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_fsm (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start_e),
    .is_div  (md_is_div_e),
    .md_busy (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed scenarios followed by randomized traffic. Each cycle the
// stimulus process computes the expected outputs from a reference model
// and pushes them into a queue; the monitor pops one entry per cycle on
// the falling edge and compares it with the DUT outputs.
module tb_hazard_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 32;

  logic       clk;
  logic       rst;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic       use_rs_d;
  logic       use_rt_d;
  logic       branch_d;
  logic       md_use_d;
  logic [4:0] wr_reg_e;
  logic       reg_write_e;
  logic       mem_to_reg_e;
  logic       md_start_e;
  logic       md_is_div_e;
  logic [4:0] wr_reg_m;
  logic       mem_to_reg_m;
  logic       flush_req;
  logic       pc_we;
  logic       we_d;
  logic       clear_d;
  logic       clear_e;
  logic       md_busy;

  hazard_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .use_rs_d     (use_rs_d),
    .use_rt_d     (use_rt_d),
    .branch_d     (branch_d),
    .md_use_d     (md_use_d),
    .wr_reg_e     (wr_reg_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .md_start_e   (md_start_e),
    .md_is_div_e  (md_is_div_e),
    .wr_reg_m     (wr_reg_m),
    .mem_to_reg_m (mem_to_reg_m),
    .flush_req    (flush_req),
    .pc_we        (pc_we),
    .we_d         (we_d),
    .clear_d      (clear_d),
    .clear_e      (clear_e),
    .md_busy      (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       branch;
    logic       md_use;
    logic [4:0] wr_e;
    logic       reg_write_e;
    logic       mem_to_reg_e;
    logic       md_start;
    logic       md_is_div;
    logic [4:0] wr_m;
    logic       mem_to_reg_m;
    logic       flush;
  } stim_t;

  typedef struct packed {
    int   cyc;
    logic pc_we;
    logic we_d;
    logic clear_d;
    logic clear_e;
    logic md_busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  // Reference model of HI/LO occupancy: the unit is busy in every cycle
  // up to and including busy_end.
  int   busy_end = -1;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic logic reads_reg(stim_t s, logic [4:0] x);
    return (x != 5'd0) && ((s.use_rs && s.rs == x) || (s.use_rt && s.rt == x));
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    logic busy;
    logic stall;
    @(posedge clk);
    #1;
    rst          = s.rst;
    rs_d         = s.rs;
    rt_d         = s.rt;
    use_rs_d     = s.use_rs;
    use_rt_d     = s.use_rt;
    branch_d     = s.branch;
    md_use_d     = s.md_use;
    wr_reg_e     = s.wr_e;
    reg_write_e  = s.reg_write_e;
    mem_to_reg_e = s.mem_to_reg_e;
    md_start_e   = s.md_start;
    md_is_div_e  = s.md_is_div;
    wr_reg_m     = s.wr_m;
    mem_to_reg_m = s.mem_to_reg_m;
    flush_req    = s.flush;

    busy  = s.rst && (cyc <= busy_end);
    stall = (s.mem_to_reg_e && reads_reg(s, s.wr_e))
         || (s.branch && ((s.reg_write_e && reads_reg(s, s.wr_e))
                          || (s.mem_to_reg_m && reads_reg(s, s.wr_m))))
         || (s.md_use && (busy || s.md_start));
    e.cyc     = cyc;
    e.md_busy = busy;
    if (s.flush) begin
      e.pc_we = 1'b1; e.we_d = 1'b1; e.clear_d = 1'b1; e.clear_e = 1'b1;
    end else begin
      e.pc_we = !stall; e.we_d = !stall; e.clear_d = 1'b0; e.clear_e = stall;
    end
    exp_q.push_back(e);

    // Effect of the coming rising edge on occupancy.
    if (!s.rst)
      busy_end = -1;
    else if (s.md_start && !busy)
      busy_end = cyc + (s.md_is_div ? DIV_LAT : MULT_LAT);
    cyc++;
  endtask

  task automatic check_bit(input string name, input int c, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s cyc %0d: got %b expected %b", name, c, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_bit("pc_we",   e.cyc, pc_we,   e.pc_we);
        check_bit("we_d",    e.cyc, we_d,    e.we_d);
        check_bit("clear_d", e.cyc, clear_d, e.clear_d);
        check_bit("clear_e", e.cyc, clear_e, e.clear_e);
        check_bit("md_busy", e.cyc, md_busy, e.md_busy);
        $display("[TB] cyc=%0d pc_we=%b we_d=%b clear_d=%b clear_e=%b md_busy=%b",
                 e.cyc, pc_we, we_d, clear_d, clear_e, md_busy);
      end
    end
  end

  initial begin
    stim_t s;
    int    waited;
    rst = 1'b0;
    rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0; branch_d = 0; md_use_d = 0;
    wr_reg_e = '0; reg_write_e = 0; mem_to_reg_e = 0; md_start_e = 0; md_is_div_e = 0;
    wr_reg_m = '0; mem_to_reg_m = 0; flush_req = 0;

    // Reset with all inputs quiet.
    s = '0;
    apply(s);
    apply(s);

    // Multiply issued on the first edge after reset release: busy 5 cycles.
    s = idle_stim(); s.md_start = 1'b1;
    apply(s);
    for (int i = 0; i < 7; i++) apply(idle_stim());

    // Load-use hit, then same with wr_reg_e = 0.
    s = idle_stim(); s.mem_to_reg_e = 1; s.wr_e = 5'd8; s.use_rs = 1; s.rs = 5'd8;
    apply(s);
    s.wr_e = 5'd0;
    apply(s);

    // Branch operand from E, then from a load in M, then cleared.
    s = idle_stim(); s.branch = 1; s.rt = 5'd9; s.use_rt = 1; s.reg_write_e = 1; s.wr_e = 5'd9;
    apply(s);
    s.reg_write_e = 0; s.wr_e = 5'd0; s.mem_to_reg_m = 1; s.wr_m = 5'd9;
    apply(s);
    s.wr_m = 5'd0;
    apply(s);

    // Flush over a load-use hit.
    s = idle_stim(); s.mem_to_reg_e = 1; s.wr_e = 5'd8; s.use_rs = 1; s.rs = 5'd8; s.flush = 1;
    apply(s);

    // Zero register never stalls.
    s = idle_stim(); s.mem_to_reg_e = 1; s.wr_e = 5'd0; s.use_rs = 1; s.rs = 5'd0;
    apply(s);

    // Divide with a HI/LO reader waiting in D the whole time.
    s = idle_stim(); s.md_start = 1; s.md_is_div = 1; s.md_use = 1;
    apply(s);
    s = idle_stim(); s.md_use = 1;
    for (int i = 0; i < DIV_LAT + 2; i++) apply(s);

    // Multiply interrupted by reset in its second busy cycle, plus a flush
    // during a fresh multiply that must not abort it.
    s = idle_stim(); s.md_start = 1;
    apply(s);
    apply(idle_stim());
    s = '0;
    apply(s);
    apply(idle_stim());
    s = idle_stim(); s.md_start = 1;
    apply(s);
    s = idle_stim(); s.flush = 1;
    apply(s);
    for (int i = 0; i < 6; i++) apply(idle_stim());

    // Randomized traffic; small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      s = idle_stim();
      s.rst          = ($urandom_range(0, 49) != 0);
      s.rs           = 5'($urandom_range(0, 3));
      s.rt           = 5'($urandom_range(0, 3));
      s.use_rs       = 1'($urandom_range(0, 1));
      s.use_rt       = 1'($urandom_range(0, 1));
      s.branch       = ($urandom_range(0, 2) == 0);
      s.md_use       = ($urandom_range(0, 3) == 0);
      s.wr_e         = 5'($urandom_range(0, 3));
      s.reg_write_e  = 1'($urandom_range(0, 1));
      s.mem_to_reg_e = ($urandom_range(0, 2) == 0);
      s.md_start     = ($urandom_range(0, 7) == 0);
      s.md_is_div    = ($urandom_range(0, 3) == 0);
      s.wr_m         = 5'($urandom_range(0, 3));
      s.mem_to_reg_m = ($urandom_range(0, 2) == 0);
      s.flush        = ($urandom_range(0, 15) == 0);
      apply(s);
    end

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(posedge clk);
      waited++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MULT_LAT, 5, cycles a mult/multu occupies the HI/LO unit.
- DIV_LAT, 32, cycles a div/divu occupies the HI/LO unit.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- rs_d, in, 5, rs field of the instruction in D.
- rt_d, in, 5, rt field of the instruction in D.
- use_rs_d, in, 1, D instruction reads rs.
- use_rt_d, in, 1, D instruction reads rt.
- branch_d, in, 1, D instruction is a branch/jr that compares or reads registers in D.
- md_use_d, in, 1, D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- wr_reg_e, in, 5, destination register of the E instruction.
- reg_write_e, in, 1, E instruction writes the register file.
- mem_to_reg_e, in, 1, E instruction is a load.
- md_start_e, in, 1, E instruction is mult/multu/div/divu.
- md_is_div_e, in, 1, qualifies md_start_e: 1 = divide.
- wr_reg_m, in, 5, destination register of the M instruction.
- mem_to_reg_m, in, 1, M instruction is a load.
- flush_req, in, 1, redirect request (exception/eret); kill D and E.
- pc_we, out, 1, PC write enable.
- we_d, out, 1, write enable to the F/D pipeline register.
- clear_d, out, 1, synchronous clear to the F/D pipeline register.
- clear_e, out, 1, synchronous clear (bubble) to the D/E pipeline register.
- md_busy, out, 1, HI/LO unit occupied.

Function
REQ-003 A register match SHALL require a nonzero register number: (use_rs_d && rs_d==X) || (use_rt_d && rt_d==X), with X != 0.
REQ-004 lu_stall SHALL be mem_to_reg_e && match(wr_reg_e).
REQ-005 br_stall SHALL be branch_d && ((reg_write_e && match(wr_reg_e)) || (mem_to_reg_m && match(wr_reg_m))).
REQ-006 md_stall SHALL be md_use_d && (md_busy || md_start_e).
REQ-007 stall SHALL be lu_stall || br_stall || md_stall.
- When stall is asserted: pc_we=0, we_d=0, clear_e=1, clear_d=0.
- When stall is deasserted: pc_we=1, we_d=1, clear_e=0, clear_d=0.
REQ-008 flush_req SHALL dominate stall: pc_we=1, we_d=1, clear_d=1, clear_e=1.
REQ-009 branch_d alone SHALL NOT assert clear_d, because the delay slot executes.
REQ-010 The stall/flush outputs SHALL be combinational, with zero-cycle latency from the inputs.
REQ-011 The HI/LO FSM SHALL have states IDLE and BUSY, plus a 5-bit down-counter cnt.
REQ-012 In IDLE, when md_start_e=1: go to BUSY and load cnt = (md_is_div_e ? DIV_LAT : MULT_LAT) - 1.
REQ-013 In BUSY with cnt != 0: decrement cnt. In BUSY with cnt == 0: go to IDLE on the next edge.
REQ-014 md_start_e while in BUSY SHALL be ignored (no reload). md_stall prevents this in legal streams.
REQ-015 md_busy SHALL be 1 exactly when the state is BUSY. A mult therefore yields md_busy high for MULT_LAT cycles, starting the cycle after md_start_e.
REQ-016 flush_req SHALL NOT abort an in-flight multiply/divide.
REQ-017 Simultaneous stall conditions SHALL produce a single stall. clear_e SHALL be asserted for every cycle any stall condition holds.

Reset
REQ-018 rst low SHALL immediately force state=IDLE, cnt=0 and md_busy=0, including mid-operation.
REQ-019 With rst low and all inputs 0, outputs SHALL be pc_we=1, we_d=1, clear_d=0, clear_e=0, md_busy=0.
REQ-020 After rst deasserts, the FSM SHALL accept md_start_e on the first rising edge.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and the MULT_LAT/DIV_LAT defaults.
REQ-022 The HI/LO busy FSM and counter SHALL be a sub-module named md_busy_fsm. The stall/flush logic SHALL remain in hazard_ctrl.

Verification
REQ-023 Load-use stall: mem_to_reg_e=1, wr_reg_e=8, use_rs_d=1, rs_d=8 -> pc_we=0, we_d=0, clear_e=1 for that cycle. Changing wr_reg_e to 0 -> no stall.
REQ-024 Branch stall: branch_d=1, rt_d=9, use_rt_d=1, reg_write_e=1, wr_reg_e=9 -> stall. Next cycle, mem_to_reg_m=1, wr_reg_m=9 -> stall again. Then wr_reg_m=0 -> no stall and clear_d=0.
REQ-025 Divide occupancy: md_start_e=1, md_is_div_e=1 -> md_busy high exactly 32 cycles. md_use_d=1 held throughout -> stall for 33 cycles (including the issue cycle), released on the cycle md_busy falls.
REQ-026 Multiply with reset mid-operation: md_start_e=1, md_is_div_e=0 -> md_busy high 5 cycles. Repeat and pull rst low at cycle 2 -> md_busy=0 immediately, state IDLE.
REQ-027 Flush over stall: flush_req=1 together with a load-use hit -> pc_we=1, we_d=1, clear_d=1, clear_e=1.
REQ-028 Zero register: rs_d=0, use_rs_d=1, mem_to_reg_e=1, wr_reg_e=0 -> no stall.
